bsg_counter_overflow_multi: RTL and testbench

BSG_COUNTER_OVERFLOW_MULTI -- requirements
Module: bsg_counter_overflow_multi

---
 rtl/bsg_counter_overflow_multi.sv | 85 ++++++++
 tb/tb_bsg_counter_overflow_multi.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/bsg_counter_overflow_multi.sv
// Bank of independent up/down wrap counters sharing one programmable limit.
// Each channel keeps a sticky flag that records a wrap since its last clear.
module bsg_counter_overflow_multi #(
   parameter int els_p     = 4,
   parameter int max_val_p = 10000000,
   localparam int width_lp = $clog2(max_val_p + 1)
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic [els_p-1:0]             en_i,
   input  logic [els_p-1:0]             down_i,
   input  logic [els_p-1:0]             set_i,
   input  logic [els_p*width_lp-1:0]    val_i,
   input  logic                         limit_v_i,
   input  logic [width_lp-1:0]          limit_i,
   input  logic [els_p-1:0]             clear_i,
   output logic [els_p*width_lp-1:0]    count_o,
   output logic [els_p-1:0]             overflow_o,
   output logic [els_p-1:0]             zero_o,
   output logic [els_p-1:0]             sticky_o,
   output logic [width_lp-1:0]          limit_o
);

   logic [els_p*width_lp-1:0] count_q, count_d;
   logic [els_p-1:0]          sticky_q, sticky_d;
   logic [width_lp-1:0]       limit_q, limit_d;
   logic [els_p-1:0]          wrap;

   always_comb begin
      count_d  = count_q;
      sticky_d = sticky_q;
      wrap     = '0;
      limit_d  = limit_v_i ? limit_i : limit_q;
      for (int i = 0; i < els_p; i++) begin
         // Compares always use the limit currently held, not the one being loaded.
         if (set_i[i]) begin
            count_d[i*width_lp +: width_lp] = val_i[i*width_lp +: width_lp];
         end else if (en_i[i]) begin
            if (down_i[i]) begin
               if (count_q[i*width_lp +: width_lp] == '0) begin
                  count_d[i*width_lp +: width_lp] = limit_q;
                  wrap[i] = 1'b1;
               end else begin
                  count_d[i*width_lp +: width_lp] = count_q[i*width_lp +: width_lp] - 1'b1;
               end
            end else begin
               if (count_q[i*width_lp +: width_lp] >= limit_q) begin
                  count_d[i*width_lp +: width_lp] = '0;
                  wrap[i] = 1'b1;
               end else begin
                  count_d[i*width_lp +: width_lp] = count_q[i*width_lp +: width_lp] + 1'b1;
               end
            end
         end
         // A wrap in the same cycle as a clear leaves the flag set.
         if (wrap[i]) begin
            sticky_d[i] = 1'b1;
         end else if (clear_i[i]) begin
            sticky_d[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         count_q  <= '0;
         sticky_q <= '0;
         limit_q  <= width_lp'(max_val_p);
      end else begin
         count_q  <= count_d;
         sticky_q <= sticky_d;
         limit_q  <= limit_d;
      end
   end

   for (genvar g = 0; g < els_p; g++) begin : g_flags
      assign overflow_o[g] = (count_q[g*width_lp +: width_lp] >= limit_q);
      assign zero_o[g]     = (count_q[g*width_lp +: width_lp] == '0);
   end

   assign count_o  = count_q;
   assign sticky_o = sticky_q;
   assign limit_o  = limit_q;

endmodule

// File: tb/tb_bsg_counter_overflow_multi.sv
// Scoreboard bench for the two-channel, limit-10 configuration: a behavioural
// model predicts each edge, the prediction is queued and compared after the edge.
module tb_bsg_counter_overflow_multi;

   localparam int els_lp = 2;
   localparam int max_lp = 10;
   localparam int w_lp   = 4;

   logic                    clk = 1'b0;
   logic                    reset_i = 1'b1;
   logic [els_lp-1:0]       en_i = '0, down_i = '0, set_i = '0, clear_i = '0;
   logic [els_lp*w_lp-1:0]  val_i = '0;
   logic                    limit_v_i = 1'b0;
   logic [w_lp-1:0]         limit_i = '0;
   logic [els_lp*w_lp-1:0]  count_o;
   logic [els_lp-1:0]       overflow_o, zero_o, sticky_o;
   logic [w_lp-1:0]         limit_o;

   always #5 clk = ~clk;

   bsg_counter_overflow_multi #(.els_p(els_lp), .max_val_p(max_lp)) dut (
      .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .down_i(down_i), .set_i(set_i),
      .val_i(val_i), .limit_v_i(limit_v_i), .limit_i(limit_i), .clear_i(clear_i),
      .count_o(count_o), .overflow_o(overflow_o), .zero_o(zero_o),
      .sticky_o(sticky_o), .limit_o(limit_o));

   typedef struct {
      logic [els_lp*w_lp-1:0] cnt;
      logic [els_lp-1:0]      sticky;
      logic [els_lp-1:0]      ovf;
      logic [els_lp-1:0]      zero;
      logic [w_lp-1:0]        limit;
   } exp_t;

   exp_t exp_q[$];
   int n_cmp = 0;
   int n_bad = 0;

   logic [w_lp-1:0]   m_cnt [els_lp];
   logic [els_lp-1:0] m_sticky = '0;
   logic [w_lp-1:0]   m_limit = 4'(max_lp);

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      if (obs !== expv) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
      end
   endtask

   // Predict the next state from the current inputs, queue it, step one edge, compare.
   task automatic cycle(input string tag);
      exp_t e;
      logic [w_lp-1:0] cur, nxt;
      logic            w;
      for (int c = 0; c < els_lp; c++) begin
         cur = m_cnt[c];
         nxt = cur;
         w   = 1'b0;
         if (set_i[c]) nxt = val_i[c*w_lp +: w_lp];
         else if (en_i[c] && down_i[c]) begin
            if (cur == 0) begin nxt = m_limit; w = 1'b1; end
            else nxt = cur - 4'd1;
         end else if (en_i[c]) begin
            if (cur >= m_limit) begin nxt = 4'd0; w = 1'b1; end
            else nxt = cur + 4'd1;
         end
         if (reset_i) begin nxt = 4'd0; w = 1'b0; end
         m_cnt[c] = nxt;
         if (reset_i) m_sticky[c] = 1'b0;
         else if (w) m_sticky[c] = 1'b1;
         else if (clear_i[c]) m_sticky[c] = 1'b0;
      end
      if (reset_i) m_limit = 4'(max_lp);
      else if (limit_v_i) m_limit = limit_i;
      for (int c = 0; c < els_lp; c++) begin
         e.cnt[c*w_lp +: w_lp] = m_cnt[c];
         e.ovf[c]  = (m_cnt[c] >= m_limit);
         e.zero[c] = (m_cnt[c] == 0);
      end
      e.sticky = m_sticky;
      e.limit  = m_limit;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check_val({tag, "_queue"}, 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         check_val({tag, "_count"},  32'(count_o),    32'(e.cnt));
         check_val({tag, "_sticky"}, 32'(sticky_o),   32'(e.sticky));
         check_val({tag, "_limit"},  32'(limit_o),    32'(e.limit));
         check_val({tag, "_ovf"},    32'(overflow_o), 32'(e.ovf));
         check_val({tag, "_zero"},   32'(zero_o),     32'(e.zero));
      end
   endtask

   task automatic idle();
      reset_i = 0; en_i = '0; down_i = '0; set_i = '0; clear_i = '0;
      limit_v_i = 0; limit_i = '0; val_i = '0;
   endtask

   initial begin
      m_cnt[0] = '0; m_cnt[1] = '0;
      #1;
      // Reset overriding loads and enables.
      reset_i = 1; set_i = 2'b11; val_i = 8'h55; en_i = 2'b11; limit_v_i = 1; limit_i = 4'd3;
      cycle("reset");
      check_val("rst_zero", 32'(zero_o), 32'h3);
      check_val("rst_ovf", 32'(overflow_o), 32'h0);
      check_val("rst_limit", 32'(limit_o), 32'd10);
      idle();

      // Channel 0 counts up to the limit, then wraps.
      en_i = 2'b01;
      for (int k = 1; k <= 10; k++) cycle("up");
      check_val("up_at10", 32'(count_o[3:0]), 32'd10);
      check_val("up_ovf10", 32'(overflow_o[0]), 32'd1);
      cycle("up_wrap");
      check_val("wrap_cnt", 32'(count_o[3:0]), 32'd0);
      check_val("wrap_sticky", 32'(sticky_o[0]), 32'd1);
      check_val("ch1_idle", 32'(count_o[7:4]), 32'd0);
      idle(); clear_i = 2'b01;
      cycle("clear0");

      // Down from zero loads the limit.
      idle(); en_i = 2'b01; down_i = 2'b01;
      cycle("down_wrap");
      check_val("down_cnt", 32'(count_o[3:0]), 32'd10);
      check_val("down_sticky", 32'(sticky_o[0]), 32'd1);
      cycle("down_9");
      check_val("down_9", 32'(count_o[3:0]), 32'd9);

      // Load above limit on channel 1 while enabled.
      idle(); set_i = 2'b10; en_i = 2'b10; val_i = 8'hF0;
      cycle("set15");
      check_val("set15_cnt", 32'(count_o[7:4]), 32'd15);
      check_val("set15_ovf", 32'(overflow_o[1]), 32'd1);
      check_val("set15_sticky", 32'(sticky_o[1]), 32'd0);
      idle(); en_i = 2'b10;
      cycle("set15_wrap");
      check_val("s15w_cnt", 32'(count_o[7:4]), 32'd0);
      check_val("s15w_sticky", 32'(sticky_o[1]), 32'd1);

      // New limit is not used on the edge that loads it.
      idle(); set_i = 2'b01; val_i = 8'h03; clear_i = 2'b11;
      cycle("set3");
      idle(); en_i = 2'b01; limit_v_i = 1; limit_i = 4'd3;
      cycle("lim_load");
      check_val("lim_old", 32'(count_o[3:0]), 32'd4);
      idle(); en_i = 2'b01;
      cycle("lim_new");
      check_val("lim_new_cnt", 32'(count_o[3:0]), 32'd0);

      // Wrap wins over a simultaneous clear.
      idle(); set_i = 2'b01; val_i = 8'h03; clear_i = 2'b01;
      cycle("pre_clr");
      idle(); en_i = 2'b01; clear_i = 2'b01;
      cycle("wrap_clr");
      check_val("wrap_clr_sticky", 32'(sticky_o[0]), 32'd1);
      idle(); clear_i = 2'b01;
      cycle("clr_only");
      check_val("clr_only_sticky", 32'(sticky_o[0]), 32'd0);

      // Hold at limit without enable.
      idle(); set_i = 2'b01; val_i = 8'h03;
      cycle("to_lim");
      idle();
      repeat (3) cycle("hold");
      check_val("hold_cnt", 32'(count_o[3:0]), 32'd3);

      // Zero limit pins enabled channels at 0 with a wrap each cycle.
      idle(); limit_v_i = 1; limit_i = 4'd0; clear_i = 2'b11;
      cycle("lim0");
      idle(); en_i = 2'b11; down_i = 2'b10;
      repeat (2) cycle("lim0_run");
      check_val("lim0_cnt", 32'(count_o), 32'd0);
      check_val("lim0_sticky", 32'(sticky_o), 32'h3);

      // Reset during loads and mid-count.
      idle(); reset_i = 1; set_i = 2'b11; val_i = 8'h77; limit_v_i = 1; limit_i = 4'd5; en_i = 2'b11;
      cycle("rst_mid");
      check_val("rst_mid_cnt", 32'(count_o), 32'd0);
      check_val("rst_mid_lim", 32'(limit_o), 32'd10);
      check_val("rst_mid_sticky", 32'(sticky_o), 32'd0);

      // Random traffic against the model.
      for (int k = 0; k < 300; k++) begin
         reset_i   = ($urandom_range(0, 63) == 0);
         en_i      = 2'($urandom);
         down_i    = 2'($urandom);
         set_i     = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
         val_i     = 8'($urandom);
         clear_i   = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
         limit_v_i = ($urandom_range(0, 15) == 0);
         limit_i   = 4'($urandom);
         cycle("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
